lfsr_core: RTL and testbench

- Generator core behind the LFSR AXI4-Lite slave register file; consumes the four 32-bit slave registers (ctrl, seed, taps, burst_len) plus their per-register write strobes.
- Produces pseudo-random words from a programmable Galois LFSR on an AXI4-Stream-style master output.
- Returns status (state, busy, done, words_sent) for the slave's read-back path.
- Sits directly downstream of the slave register block inside the same IP.

---
 rtl/lfsr_core_if.sv | 9 +
 rtl/lfsr_core.sv | 92 +++++++++
 tb/tb_lfsr_core.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_core_if.sv
// lfsr_core_if: AXI4-Stream-style word channel between the LFSR core and its consumer
interface lfsr_core_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;
    modport master(output tdata, tvalid, tlast, input tready);
    modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/lfsr_core.sv
// lfsr_core: programmable Galois LFSR word generator with one-shot/continuous stream output and status
module lfsr_core #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [31:0]          ctrl_reg,
    input  logic [WIDTH-1:0]     seed_reg,
    input  logic [WIDTH-1:0]     taps_reg,
    input  logic [CNT_WIDTH-1:0] burst_len,
    input  logic [3:0]           reg_wr_strb,
    lfsr_core_if.master          m,
    output logic [1:0]           state_o,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] words_sent
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] DRAIN = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    logic [1:0]           state, state_nxt;
    logic [WIDTH-1:0]     lfsr, lfsr_step;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 ctrl_wr, en, one_shot, clr_cnt;
    logic                 hs, start, stop, issue, last;
    logic                 unused_ctrl;

    assign ctrl_wr     = reg_wr_strb[0];
    assign en          = ctrl_reg[0];
    assign one_shot    = ctrl_reg[1];
    assign clr_cnt     = ctrl_reg[2];
    assign unused_ctrl = ^ctrl_reg[31:3];

    assign hs        = m.tvalid && m.tready;
    assign start     = ctrl_wr && en && (state == IDLE || state == DONE);
    assign stop      = ctrl_wr && !en && state == RUN;
    assign issue     = state == RUN && !stop && (!m.tvalid || m.tready);
    assign last      = one_shot && remaining == CNT_WIDTH'(1);
    assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? taps_reg : '0);

    assign state_o = state;
    assign busy    = state == RUN || state == DRAIN;
    assign done    = state == DONE;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? ((one_shot && burst_len == '0) ? DONE : RUN)
                                  : (state == DONE && ctrl_wr && !en) ? IDLE : state;
            RUN:        state_nxt = (stop || (issue && last)) ? DRAIN : RUN;
            default:    state_nxt = !m.tvalid ? IDLE : m.tready ? (m.tlast ? DONE : IDLE) : DRAIN;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            lfsr       <= WIDTH'(1);
            remaining  <= '0;
            m.tdata    <= '0;
            m.tvalid   <= 1'b0;
            m.tlast    <= 1'b0;
            words_sent <= '0;
        end else begin
            state <= state_nxt;
            // a seed load overrides the step so the new seed is the next word emitted
            if (reg_wr_strb[1])
                lfsr <= (seed_reg == '0) ? WIDTH'(1) : seed_reg;
            else if (issue)
                lfsr <= lfsr_step;
            if (start)
                remaining <= burst_len;
            else if (issue)
                remaining <= remaining - CNT_WIDTH'(1);
            if (issue) begin
                m.tdata  <= lfsr;
                m.tvalid <= 1'b1;
                m.tlast  <= last;
            end else if (hs) begin
                m.tvalid <= 1'b0;
                m.tlast  <= 1'b0;
            end
            if (ctrl_wr && clr_cnt)
                words_sent <= '0;
            else if (hs && !(&words_sent))
                words_sent <= words_sent + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_lfsr_core.sv
// tb_lfsr_core: randomized and directed checks of lfsr_core against a sequence-level stream model
module tb_lfsr_core;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] ctrl_reg = '0, seed_reg = '0, taps_reg = '0, burst_len = '0;
    logic [3:0]  reg_wr_strb = '0;
    logic [1:0]  state_o;
    logic        busy, done;
    logic [31:0] words_sent;
    lfsr_core_if #(.WIDTH(32)) s_if();

    lfsr_core #(.WIDTH(32), .CNT_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .ctrl_reg(ctrl_reg), .seed_reg(seed_reg),
        .taps_reg(taps_reg), .burst_len(burst_len), .reg_wr_strb(reg_wr_strb),
        .m(s_if), .state_o(state_o), .busy(busy), .done(done), .words_sent(words_sent)
    );

    always #5 ACLK = ~ACLK;

    int          vectors = 0, miscompares = 0;
    int          hs_n = 0, tlast_n = 0, bcnt = 0;
    logic        rnd_rdy = 1'b0, arm = 1'b0, m_os = 1'b0;
    logic [31:0] exp_w = 32'd1, cnt = '0, m_blen = '0;
    logic [31:0] hs_log[$];

    function automatic logic [31:0] step(input logic [31:0] s, input logic [31:0] t);
        return s[0] ? ((s >> 1) ^ t) : (s >> 1);
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", n, a, e);
        end
    endtask

    // Model: accepted words form one unbroken LFSR sequence from the last seed
    task automatic monitor();
        logic hs;
        if (!ARESETN) begin
            exp_w = 32'd1; cnt = '0; bcnt = 0; m_os = 1'b0; m_blen = '0;
            return;
        end
        hs = s_if.tvalid && s_if.tready;
        chk("busy", busy, state_o == 2'd1 || state_o == 2'd2);
        chk("done", done, state_o == 2'd3);
        chk("words_sent", words_sent, cnt);
        if (s_if.tvalid) begin
            chk("tdata", s_if.tdata, exp_w);
            chk("tlast", s_if.tlast, m_os && (bcnt + 1 == int'(m_blen)));
        end
        if (state_o == 2'd0 || state_o == 2'd3) chk("tvalid_at_rest", s_if.tvalid, 0);
        if (hs) begin
            hs_log.push_back(s_if.tdata);
            tlast_n += int'(s_if.tlast);
            hs_n++;
            bcnt++;
            exp_w = step(exp_w, taps_reg);
        end
        if (reg_wr_strb[0] && ctrl_reg[2]) cnt = '0;
        else if (hs && cnt != '1) cnt++;
        if (reg_wr_strb[1]) exp_w = (seed_reg == '0) ? 32'd1 : seed_reg;
        if (arm && reg_wr_strb[0]) begin
            m_os = ctrl_reg[1]; m_blen = burst_len; bcnt = 0;
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        monitor();
        @(posedge ACLK);
        #1;
        if (rnd_rdy) s_if.tready = $urandom_range(0, 3) != 0;
    endtask

    task automatic wr(input int i, input logic [31:0] v);
        case (i)
            0: ctrl_reg = v;
            1: seed_reg = v;
            2: taps_reg = v;
            default: burst_len = v;
        endcase
        reg_wr_strb = 4'b1 << i;
        tick();
        reg_wr_strb = '0;
    endtask

    task automatic start(input logic [31:0] v);
        arm = 1'b1;
        wr(0, v);
        arm = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim);
        int i = 0;
        while (state_o !== s && i < lim) begin
            tick();
            i++;
        end
        chk("wait_state", state_o, s);
    endtask

    task automatic wait_valid(input int lim);
        int i = 0;
        while (s_if.tvalid !== 1'b1 && i < lim) begin
            tick();
            i++;
        end
        chk("wait_valid", s_if.tvalid, 1);
    endtask

    initial begin
        int h0, t0, n;
        logic os;
        logic [31:0] blen;
        s_if.tready = 1'b0;
        repeat (2) tick();
        chk("rst_state", state_o, 0);
        chk("rst_tvalid", s_if.tvalid, 0);
        chk("rst_tdata", s_if.tdata, 0);
        chk("rst_tlast", s_if.tlast, 0);
        chk("rst_words", words_sent, 0);
        chk("rst_busy_done", {busy, done}, 0);
        ARESETN = 1'b1;
        tick();

        // reference sequence, counting, and stop with a pending word
        wr(2, 32'h8020_0003);
        wr(1, 32'h0000_0001);
        start(32'h1);
        chk("latency_pre", s_if.tvalid, 0);
        tick();
        chk("latency", s_if.tvalid, 1);
        s_if.tready = 1'b1;
        repeat (3) tick();
        s_if.tready = 1'b0;
        chk("words_3", words_sent, 3);
        chk("seq0", hs_log[0], 32'h0000_0001);
        chk("seq1", hs_log[1], 32'h8020_0003);
        chk("seq2", hs_log[2], 32'hC030_0002);
        wr(0, 32'h0);
        chk("stop_drain", state_o, 2);
        chk("stop_busy", busy, 1);
        chk("stop_pending", s_if.tvalid, 1);
        s_if.tready = 1'b1;
        tick();
        s_if.tready = 1'b0;
        chk("drain_valid", s_if.tvalid, 0);
        chk("drain_idle", state_o, 0);
        chk("drain_words", words_sent, 4);
        chk("seq3", hs_log[3], 32'h6018_0001);

        // counter clear beats a simultaneous handshake
        start(32'h1);
        wait_valid(5);
        ctrl_reg = 32'h5;
        reg_wr_strb = 4'b0001;
        s_if.tready = 1'b1;
        tick();
        reg_wr_strb = '0;
        s_if.tready = 1'b0;
        chk("clr_wins", words_sent, 0);
        wr(0, 32'h0);
        s_if.tready = 1'b1;
        wait_state(2'd0, 10);
        s_if.tready = 1'b0;

        // zero seed is replaced by 1
        wr(1, 32'h0);
        start(32'h1);
        wait_valid(5);
        chk("zero_seed", s_if.tdata, 1);
        wr(0, 32'h0);
        s_if.tready = 1'b1;
        wait_state(2'd0, 10);

        // one-shot burst of 4
        wr(3, 32'd4);
        h0 = hs_n; t0 = tlast_n;
        start(32'h3);
        wait_state(2'd3, 40);
        chk("burst_words", hs_n - h0, 4);
        chk("burst_tlast", tlast_n - t0, 1);
        chk("burst_done", done, 1);
        wr(0, 32'h0);
        chk("burst_idle", state_o, 0);
        s_if.tready = 1'b0;

        // backpressure holds the pending word
        start(32'h1);
        wait_valid(5);
        repeat (5) tick();
        chk("bp_valid", s_if.tvalid, 1);
        chk("bp_data", s_if.tdata, exp_w);
        chk("bp_words", words_sent, cnt);
        s_if.tready = 1'b1;
        repeat (3) tick();
        wr(0, 32'h0);
        wait_state(2'd0, 10);

        // empty one-shot burst
        wr(3, 32'd0);
        start(32'h3);
        chk("empty_done", state_o, 3);
        chk("empty_valid", s_if.tvalid, 0);
        repeat (3) tick();
        chk("empty_still", s_if.tvalid, 0);
        wr(0, 32'h0);
        chk("empty_idle", state_o, 0);

        // asynchronous reset mid-burst
        wr(3, 32'd20);
        start(32'h3);
        rnd_rdy = 1'b1;
        repeat (6) tick();
        ARESETN = 1'b0;
        #1;
        chk("arst_valid", s_if.tvalid, 0);
        chk("arst_words", words_sent, 0);
        chk("arst_state", state_o, 0);
        tick();
        ARESETN = 1'b1;
        tick();

        // randomized phases
        for (int p = 0; p < 40; p++) begin
            wr(2, $urandom | 32'h8000_0000);
            wr(1, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
            os = 1'($urandom_range(0, 1));
            blen = $urandom_range(0, 6);
            wr(3, blen);
            start({29'b0, 1'($urandom_range(0, 1)), os, 1'b1});
            if (os) begin
                wr(3, $urandom_range(1, 9));
                wait_state(2'd3, 200);
                chk("rnd_burst_len", bcnt, blen);
            end else begin
                n = $urandom_range(5, 30);
                for (int i = 0; i < n; i++)
                    if ($urandom_range(0, 7) == 0) wr(3, $urandom); else tick();
                wr(0, 32'h0);
                wait_state(2'd0, 100);
            end
            wr(0, 32'h0);
            wait_state(2'd0, 5);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
